// File: rtl/reg_pkg.sv
// Shared types for the function-select register: funsel encodings and step direction.
package reg_pkg;

    typedef enum logic [1:0] {
        FUNSEL_CLR = 2'b00,
        FUNSEL_LD  = 2'b01,
        FUNSEL_DEC = 2'b10,
        FUNSEL_INC = 2'b11
    } funsel_t;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_t;

endpackage

// File: rtl/funsel_register_if.sv
// Control/data bundle for funsel_register: enable, function select, load data and registered output.
interface funsel_register_if #(
    parameter int NBits = 4
);
    logic             e;
    logic [1:0]       funsel;
    logic [NBits-1:0] i;
    logic [NBits-1:0] q;

    modport master (
        output e,
        output funsel,
        output i,
        input  q
    );

    modport slave (
        input  e,
        input  funsel,
        input  i,
        output q
    );
endinterface

// File: rtl/reg_incdec.sv
// Combinational +1/-1 step of the register value.
// Wraps modulo 2^NBits by default; saturates at 0 / all ones when REG_SATURATE_EN is defined.
module reg_incdec
    import reg_pkg::*;
#(
    parameter int NBits = 4
) (
    input  logic [NBits-1:0] q,
    input  dir_t             dir,
    output logic [NBits-1:0] next_q
);
    localparam logic [NBits-1:0] ONE = NBits'(1);

    always_comb begin
        next_q = q;
`ifdef REG_SATURATE_EN
        if (dir == DIR_INC) begin
            if (q != '1) next_q = q + ONE;
        end else begin
            if (q != '0) next_q = q - ONE;
        end
`else
        if (dir == DIR_INC) next_q = q + ONE;
        else                next_q = q - ONE;
`endif
    end
endmodule

// File: rtl/funsel_register.sv
// N-bit register with clear/load/decrement/increment selected by funsel, gated by e.
// Optional saturating inc/dec via the REG_SATURATE_EN macro (see reg_incdec).
module funsel_register
    import reg_pkg::*;
#(
    parameter int NBits = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    funsel_register_if.slave bus
);
    funsel_t          fs;
    dir_t             dir;
    logic [NBits-1:0] q_reg;
    logic [NBits-1:0] step_q;
    logic [NBits-1:0] d;

    assign fs  = funsel_t'(bus.funsel);
    assign dir = (fs == FUNSEL_INC) ? DIR_INC : DIR_DEC;

    reg_incdec #(.NBits(NBits)) u_incdec (
        .q      (q_reg),
        .dir    (dir),
        .next_q (step_q)
    );

    // With e low the mux falls through to the current value, so the flop simply reloads itself.
    always_comb begin
        d = q_reg;
        if (bus.e) begin
            case (fs)
                FUNSEL_CLR: d = '0;
                FUNSEL_LD:  d = bus.i;
                FUNSEL_DEC: d = step_q;
                FUNSEL_INC: d = step_q;
                default:    d = q_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_reg <= '0;
        else        q_reg <= d;
    end

    assign bus.q = q_reg;
endmodule

// File: tb/tb_funsel_register.sv
// Randomised self-checking bench for funsel_register against an arithmetic reference model.
module tb_funsel_register;
    localparam int NB   = 4;
    localparam int MAXV = (1 << NB) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    funsel_register_if #(.NBits(NB)) bus ();

    funsel_register #(.NBits(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_q      = 0;

    // Reference: the next value from the operation rules, using plain integer arithmetic.
    function automatic int ref_next(int cur, bit en, int fs, int din);
        if (!en) return cur;
        case (fs)
            0: return 0;
            1: return din & MAXV;
`ifdef REG_SATURATE_EN
            2: return (cur == 0) ? 0 : cur - 1;
            3: return (cur == MAXV) ? MAXV : cur + 1;
`else
            2: return (cur + MAXV) % (MAXV + 1);
            3: return (cur + 1) % (MAXV + 1);
`endif
            default: return cur;
        endcase
    endfunction

    task automatic drive_edge(input bit en, input int fs, input int din);
        bus.e      = en;
        bus.funsel = fs[1:0];
        bus.i      = din[NB-1:0];
        @(posedge clk);
        #1;
        if (rst_n) model_q = ref_next(model_q, en, fs, din);
        else       model_q = 0;
    endtask

    task automatic test_reset();
        bus.e = 1'b1; bus.funsel = 2'b01; bus.i = 4'b1111;
        rst_n = 1'b0;
        model_q = 0;
        #1;
        tests_run++;
        if (bus.q !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: q=%b expected 0000", bus.q);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.q !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold: q=%b expected 0000", bus.q);
            end
        end
        rst_n = 1'b1;
        drive_edge(1'b1, 1, 15);
        tests_run++;
        if (bus.q !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_load: q=%b expected 1111", bus.q);
        end
    endtask

    task automatic test_load_clear();
        int vals[5] = '{15, 10, 1, 6, 0};
        foreach (vals[k]) begin
            drive_edge(1'b1, 1, vals[k]);
            tests_run++;
            if (bus.q !== NB'(vals[k])) begin
                tests_failed++;
                $display("[TB] FAIL load: q=%b expected %b", bus.q, NB'(vals[k]));
            end
            drive_edge(1'b1, 0, vals[k] ^ 5);
            tests_run++;
            if (bus.q !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL clear: q=%b expected 0000", bus.q);
            end
        end
    endtask

    task automatic test_count(input int fs, input string name, input int final_q);
        drive_edge(1'b1, 0, $urandom);
        for (int k = 0; k < 17; k++) begin
            drive_edge(1'b1, fs, $urandom);
            tests_run++;
            if (bus.q !== NB'(model_q)) begin
                tests_failed++;
                $display("[TB] FAIL %s_step%0d: q=%0d expected %0d", name, k, bus.q, model_q);
            end
        end
        tests_run++;
        if (bus.q !== NB'(final_q)) begin
            tests_failed++;
            $display("[TB] FAIL %s_final: q=%0d expected %0d", name, bus.q, final_q);
        end
    endtask

    task automatic test_hold();
        drive_edge(1'b1, 1, 5);
        for (int fs = 0; fs < 4; fs++) begin
            drive_edge(1'b0, fs, $urandom);
            tests_run++;
            if (bus.q !== 4'b0101) begin
                tests_failed++;
                $display("[TB] FAIL hold_fs%0d: q=%b expected 0101", fs, bus.q);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drive_edge(1'b1, 1, 3);
        drive_edge(1'b1, 3, 0);
        drive_edge(1'b1, 3, 0);
        #2;
        rst_n   = 1'b0;
        model_q = 0;
        #1;
        tests_run++;
        if (bus.q !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_async: q=%b expected 0000", bus.q);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.q !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_edge: q=%b expected 0000", bus.q);
        end
        rst_n = 1'b1;
        drive_edge(1'b1, 3, 0);
        tests_run++;
        if (bus.q !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_restart: q=%b expected 0001", bus.q);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive_edge(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom);
            tests_run++;
            if (bus.q !== NB'(model_q)) begin
                tests_failed++;
                $display("[TB] FAIL random%0d: q=%0d expected %0d", k, bus.q, model_q);
            end
        end
    endtask

    initial begin
        bus.e = 1'b0; bus.funsel = 2'b00; bus.i = '0;
        test_reset();
        test_load_clear();
`ifdef REG_SATURATE_EN
        test_count(3, "inc", 15);
        test_count(2, "dec", 0);
`else
        test_count(3, "inc", 1);
        test_count(2, "dec", 15);
`endif
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
